alu_mul_ctrl: RTL
=================

Name: alu_mul_ctrl

Overview:
Issue/completion controller between the EX-stage decode and the multi-cycle multiplier unit (alu_mul_top).
- Accepts one RV64M multiply request from EX and latches operands.
- Drives the multiplier's signedness and valid/ready handshake.
- Stalls EX until the product returns, then formats the 128-bit product into the 64-bit rd value.
- Handles pipeline flush while a multiply is in flight.

Parameters:
XLEN, 64, datapath width (from `XLEN in sysconfig.v)

Ports:
clk  in  1  clock; single clock domain
rst  in  1  synchronous, active-high reset
mul_req_i  in  1  EX holds a valid multiply instruction
mul_op_i  in  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW; 5-7 illegal, treated as MUL
rs1_i  in  XLEN  operand 1 from EX
rs2_i  in  XLEN  operand 2 from EX
flush_i  in  1  pipeline flush (redirect/trap)
ex_stall_o  out  1  freeze EX/upstream stages
mul_result_o  out  XLEN  formatted rd value
mul_result_valid_o  out  1  result valid for exactly one cycle
mul_valid_o  out  1  to multiplier mul_valid_i
mul_rs1_signed_o  out  1  to rs1_signed_valid_i
mul_rs2_signed_o  out  1  to rs2_signed_valid_i
mul_rs1_o  out  XLEN  to rs1_data_i
mul_rs2_o  out  XLEN  to rs2_data_i
mul_ready_i  in  1  from multiplier mul_ready_o
mul_out_i  in  2*XLEN  from multiplier mul_out_o; valid in the cycle mul_ready_i=1

Behaviour:
- Reset: state IDLE; all registered outputs 0 (mul_valid_o, mul_result_valid_o, mul_result_o, latched operands and op). ex_stall_o=0.
- States: IDLE, BUSY, DONE, DRAIN. Encodings are local.
- IDLE:
  - mul_req_i=1 and flush_i=0: latch op and operands; go to BUSY; ex_stall_o=1 combinationally in this cycle.
  - mul_req_i=1 and flush_i=1: request ignored; stay in IDLE; ex_stall_o=0.
- Operand latch:
  - MULW: rs1/rs2 low 32 bits sign-extended to XLEN; both signed flags 1.
  - MUL: raw operands, flags 0/0.
  - MULH: 1/1. MULHSU: 1/0. MULHU: 0/0.
- BUSY:
  - mul_valid_o=1; operands and flags held stable from registers until mul_ready_i=1 is sampled.
  - ex_stall_o=1.
  - On mul_ready_i=1: register the formatted result and go to DONE.
- Result formatting:
  - MUL: mul_out_i[63:0].
  - MULH/MULHSU/MULHU: mul_out_i[127:64].
  - MULW: sign-extend mul_out_i[31:0].
- DONE:
  - mul_result_valid_o=1, mul_valid_o=0, ex_stall_o=0; EX advances this cycle.
  - mul_req_i is ignored (it is the same instruction); next state IDLE unconditionally.
- Flush in BUSY (the multiplier cannot be aborted):
  - Go to DRAIN; mul_valid_o stays 1 with operands unchanged.
  - If mul_ready_i=1 in the flush cycle: go directly to IDLE; result discarded; no DONE.
- DRAIN:
  - mul_valid_o=1; ex_stall_o = mul_req_i, so a new post-flush instruction waits.
  - On mul_ready_i=1: discard mul_out_i and go to IDLE. mul_result_valid_o never asserts.
  - A pending request is then accepted normally in IDLE.
  - flush_i in DRAIN: no effect.
- Flush in DONE: mul_result_valid_o is still asserted; the writeback stage owns the squash. Next state IDLE.
- Latency: request at cycle T → mul_valid_o at T+1 → mul_ready_i at T+k (k≥1) → result valid at T+k+1. Minimum is 2 cycles when the multiplier responds in the first valid cycle.
- Reset mid-operation: return to IDLE next edge; in-flight product discarded. The multiplier shares rst.
- mul_result_o holds its last value outside DONE; consumers qualify it with mul_result_valid_o.

Decomposition:
- sysconfig.v: add op encodings as `ALU_MUL_OP_MUL … `ALU_MUL_OP_MULW and `ALU_MUL_OP_BUS (3 bits), shared with the decoder.
- One combinational sub-module, alu_mul_fmt: (op, 128-bit product) → 64-bit rd value.
- FSM, operand latch and handshake stay in alu_mul_ctrl.

Test Plan:
- MUL, rs1=3, rs2=-5 (0xFFFF_FFFF_FFFF_FFFB), ready 3 cycles after valid → result 0xFFFF_FFFF_FFFF_FFF1; stall high 4 cycles; result_valid exactly 1 cycle; operands stable throughout BUSY.
- MULH/MULHSU/MULHU, rs1=rs2=0x8000_0000_0000_0000 → flags 1/1, 1/0, 0/0; results 0x4000_0000_0000_0000, 0xC000_0000_0000_0000, 0x4000_0000_0000_0000.
- MULW, rs1=0x1_7FFF_FFFF, rs2=2 → latched rs1=0x7FFF_FFFF, result 0xFFFF_FFFF_FFFF_FFFE.
- Multiplier ready in the first valid cycle → result valid 2 cycles after request; back-to-back MULs separated by exactly one IDLE cycle.
- flush_i 1 cycle after accept, new MUL request held, ready 4 cycles later → mul_valid_o held through DRAIN; no result_valid for the flushed op; stall held; new op issued the cycle after drain, result correct.
- rst asserted in BUSY → next cycle: IDLE, mul_valid_o=0, stall 0, no result_valid; a subsequent request completes normally.

Source files
------------

// File: rtl/alu_mul_ctrl_pkg.sv
// Shared types and helpers for the EX-stage multiply issue/completion controller.
package alu_mul_ctrl_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned HALF = 32;
    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_MULW   = 3'd4
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic            rs1_signed;
        logic            rs2_signed;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } mul_opnd_t;

    // Unused encodings 5-7 collapse onto MUL.
    function automatic mul_op_e decode_op(logic [OP_W-1:0] raw);
        case (raw)
            3'd1:    return OP_MULH;
            3'd2:    return OP_MULHSU;
            3'd3:    return OP_MULHU;
            3'd4:    return OP_MULW;
            default: return OP_MUL;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] sext_w(logic [HALF-1:0] v);
        return {{(XLEN-HALF){v[HALF-1]}}, v};
    endfunction

endpackage

// File: rtl/alu_mul_fmt.sv
// Selects/extends the 128-bit multiplier product into the 64-bit rd value.
module alu_mul_fmt
    import alu_mul_ctrl_pkg::*;
(
    input  mul_op_e               op_i,
    input  logic [2*XLEN-1:0]     prod_i,
    output logic [XLEN-1:0]       rd_c_o
);

    always_comb begin
        rd_c_o = prod_i[XLEN-1:0];
        case (op_i)
            OP_MULH, OP_MULHSU, OP_MULHU: rd_c_o = prod_i[2*XLEN-1:XLEN];
            OP_MULW:                      rd_c_o = sext_w(prod_i[HALF-1:0]);
            default:                      rd_c_o = prod_i[XLEN-1:0];
        endcase
    end

endmodule

// File: rtl/alu_mul_ctrl.sv
// Issue/completion controller between EX decode and the multi-cycle multiplier.
module alu_mul_ctrl
    import alu_mul_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mul_req_i,
    input  logic [OP_W-1:0]       mul_op_i,
    input  logic [XLEN-1:0]       rs1_i,
    input  logic [XLEN-1:0]       rs2_i,
    input  logic                  flush_i,
    output logic                  ex_stall_o,
    output logic [XLEN-1:0]       mul_result_o,
    output logic                  mul_result_valid_o,
    output logic                  mul_valid_o,
    output logic                  mul_rs1_signed_o,
    output logic                  mul_rs2_signed_o,
    output logic [XLEN-1:0]       mul_rs1_o,
    output logic [XLEN-1:0]       mul_rs2_o,
    input  logic                  mul_ready_i,
    input  logic [2*XLEN-1:0]     mul_out_i
);

    state_e          state_q, state_d;
    mul_op_e         op_q, op_dec;
    mul_opnd_t       opnd_q, opnd_d;
    logic            valid_q, valid_d;
    logic            res_valid_q, res_valid_d;
    logic [XLEN-1:0] result_q, fmt_rd;
    logic            accept, capture;

    assign op_dec = decode_op(mul_op_i);

    // Operand conditioning and signedness per opcode.
    always_comb begin
        opnd_d.rs1        = rs1_i;
        opnd_d.rs2        = rs2_i;
        opnd_d.rs1_signed = 1'b0;
        opnd_d.rs2_signed = 1'b0;
        case (op_dec)
            OP_MULH: begin
                opnd_d.rs1_signed = 1'b1;
                opnd_d.rs2_signed = 1'b1;
            end
            OP_MULHSU: opnd_d.rs1_signed = 1'b1;
            OP_MULW: begin
                opnd_d.rs1        = sext_w(rs1_i[HALF-1:0]);
                opnd_d.rs2        = sext_w(rs2_i[HALF-1:0]);
                opnd_d.rs1_signed = 1'b1;
                opnd_d.rs2_signed = 1'b1;
            end
            default: ;
        endcase
    end

    alu_mul_fmt u_fmt (
        .op_i   (op_q),
        .prod_i (mul_out_i),
        .rd_c_o (fmt_rd)
    );

    // Next-state, stall and handshake decode.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        capture    = 1'b0;
        ex_stall_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mul_req_i && !flush_i) begin
                    accept     = 1'b1;
                    ex_stall_o = 1'b1;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                ex_stall_o = 1'b1;
                if (flush_i) begin
                    state_d = mul_ready_i ? ST_IDLE : ST_DRAIN;
                end else if (mul_ready_i) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_DRAIN: begin
                // A post-flush instruction waits until the orphaned product returns.
                ex_stall_o = mul_req_i;
                if (mul_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d     = (state_d == ST_BUSY) || (state_d == ST_DRAIN);
        res_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MUL;
            opnd_q      <= '0;
            valid_q     <= 1'b0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            res_valid_q <= res_valid_d;
            if (accept) begin
                op_q   <= op_dec;
                opnd_q <= opnd_d;
            end
            if (capture) begin
                result_q <= fmt_rd;
            end
        end
    end

    assign mul_valid_o        = valid_q;
    assign mul_result_valid_o = res_valid_q;
    assign mul_result_o       = result_q;
    assign mul_rs1_o          = opnd_q.rs1;
    assign mul_rs2_o          = opnd_q.rs2;
    assign mul_rs1_signed_o   = opnd_q.rs1_signed;
    assign mul_rs2_signed_o   = opnd_q.rs2_signed;

endmodule
